// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: power-up / recovery sequencer for the PLL and the system reset tree.
// Runs from the 16 MHz reference clock, so it keeps working while the PLL is down.
// Optional watchdog: define PLL_RST_WDOG_EN to enable it (cause code 11).
module pll_reset_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PLL_RST_CYC = 16,
  parameter int unsigned LOCK_CYC    = 256,
  parameter int unsigned LOCK_TO_CYC = 65535,
  parameter int unsigned SYS_RST_CYC = 255,
  parameter int unsigned CPU_DLY_CYC = 16,
  parameter int unsigned WDOG_CYC    = 65535
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pll_lock,
  input  logic       i_sw_reset_req,
  input  logic       i_wdog_kick,
  output logic       o_pll_resetb,
  output logic       o_sys_reset,
  output logic       o_cpu_reset,
  output logic [1:0] o_rst_cause,
  output logic [3:0] o_lock_fails,
  output logic [2:0] o_seq_state
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StSysRst   = 3'd2,
    StCpuRst   = 3'd3,
    StRun      = 3'd4
  } state_e;

  localparam logic [1:0] CausePor  = 2'b00;
  localparam logic [1:0] CauseLock = 2'b01;
  localparam logic [1:0] CauseSw   = 2'b10;
  localparam logic [1:0] CauseWdog = 2'b11;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_d;
  logic             r_lock_s1, r_lock_s2;
  logic             w_lock_ok, w_lock_fail, w_wdog_expire;
  logic [1:0]       r_rst_cause, w_rst_cause_d;
  logic [3:0]       r_lock_fails;
  logic             r_pll_resetb, r_sys_reset, r_cpu_reset;
  logic             w_pll_resetb_d, w_sys_reset_d, w_cpu_reset_d;

  logic w_exp_pll, w_exp_to, w_exp_sys, w_exp_cpu;
  assign w_exp_pll = (r_cnt == CNT_W'(PLL_RST_CYC - 1));
  assign w_exp_to  = (r_cnt == CNT_W'(LOCK_TO_CYC - 1));
  assign w_exp_sys = (r_cnt == CNT_W'(SYS_RST_CYC - 1));
  assign w_exp_cpu = (r_cnt == CNT_W'(CPU_DLY_CYC - 1));

  // Lock filter only counts while waiting for lock, so every PLL reset needs a fresh lock.
  assign w_lock_ok = (r_lock_cnt == CNT_W'(LOCK_CYC));

  always_comb begin
    if (r_state != StWaitLock || !r_lock_s2) begin
      w_lock_cnt_d = '0;
    end else if (!w_lock_ok) begin
      w_lock_cnt_d = r_lock_cnt + CNT_W'(1);
    end else begin
      w_lock_cnt_d = r_lock_cnt;
    end
  end

`ifdef PLL_RST_WDOG_EN
  logic [CNT_W-1:0] r_wdog_cnt, w_wdog_cnt_d;

  // Watchdog runs only in RUN; a kick in the expiry cycle wins.
  assign w_wdog_cnt_d  = (r_state != StRun || i_wdog_kick) ? '0 : r_wdog_cnt + CNT_W'(1);
  assign w_wdog_expire = (r_state == StRun) && !i_wdog_kick &&
                         (r_wdog_cnt == CNT_W'(WDOG_CYC - 1));

  // Watchdog counter register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_wdog_cnt <= '0;
    else            r_wdog_cnt <= w_wdog_cnt_d;
  end
`else
  logic             w_unused_kick;
  logic [CNT_W-1:0] w_unused_wdog;
  assign w_unused_kick = i_wdog_kick;
  assign w_unused_wdog = CNT_W'(WDOG_CYC);
  assign w_wdog_expire = 1'b0;
`endif

  // Lock synchroniser and lock filter counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lock_s1  <= 1'b0;
      r_lock_s2  <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_lock_s1  <= i_pll_lock;
      r_lock_s2  <= r_lock_s1;
      r_lock_cnt <= w_lock_cnt_d;
    end
  end

  // State register and shared sequence counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StPllRst;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state logic: sequencing, then reset events (lock loss > watchdog > sw request)
  always_comb begin
    w_state_d     = r_state;
    w_rst_cause_d = r_rst_cause;
    w_lock_fail   = 1'b0;
    case (r_state)
      StPllRst:   if (w_exp_pll) w_state_d = StWaitLock;
      StWaitLock: begin
        if (w_lock_ok) begin
          w_state_d = StSysRst;
        end else if (w_exp_to) begin
          w_state_d   = StPllRst;
          w_lock_fail = 1'b1;
        end
      end
      StSysRst:   if (w_exp_sys) w_state_d = StCpuRst;
      StCpuRst:   if (w_exp_cpu) w_state_d = StRun;
      StRun:      w_state_d = StRun;
      default:    w_state_d = StPllRst;
    endcase
    if (r_state inside {StSysRst, StCpuRst, StRun}) begin
      if (!r_lock_s2) begin
        w_state_d     = StPllRst;
        w_rst_cause_d = CauseLock;
      end else if (w_wdog_expire) begin
        w_state_d     = StSysRst;
        w_rst_cause_d = CauseWdog;
      end else if (i_sw_reset_req && r_state != StSysRst) begin
        // Software reset keeps the PLL running and skips re-lock.
        w_state_d     = StSysRst;
        w_rst_cause_d = CauseSw;
      end
    end
  end

  assign w_cnt_d = (w_state_d != r_state) ? '0 : r_cnt + CNT_W'(1);

  // Output decode from next state so the registered resets change on the transition edge
  always_comb begin
    w_pll_resetb_d = (w_state_d != StPllRst);
    w_sys_reset_d  = (w_state_d inside {StPllRst, StWaitLock, StSysRst});
    w_cpu_reset_d  = (w_state_d != StRun);
  end

  // Registered outputs, reset cause and saturating lock-failure count
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pll_resetb <= 1'b0;
      r_sys_reset  <= 1'b1;
      r_cpu_reset  <= 1'b1;
      r_rst_cause  <= CausePor;
      r_lock_fails <= 4'd0;
    end else begin
      r_pll_resetb <= w_pll_resetb_d;
      r_sys_reset  <= w_sys_reset_d;
      r_cpu_reset  <= w_cpu_reset_d;
      r_rst_cause  <= w_rst_cause_d;
      if (w_lock_fail && r_lock_fails != 4'hF) r_lock_fails <= r_lock_fails + 4'd1;
    end
  end

  assign o_pll_resetb = r_pll_resetb;
  assign o_sys_reset  = r_sys_reset;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_rst_cause  = r_rst_cause;
  assign o_lock_fails = r_lock_fails;
  assign o_seq_state  = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (short timing parameters).
module tb_pll_reset_sequencer;

  localparam int unsigned PLL_RST_CYC = 4;
  localparam int unsigned LOCK_CYC    = 8;
  localparam int unsigned LOCK_TO_CYC = 64;
  localparam int unsigned SYS_RST_CYC = 10;
  localparam int unsigned CPU_DLY_CYC = 3;
  localparam int unsigned WDOG_CYC    = 32;

  logic       clk = 1'b0;
  logic       reset_n, pll_lock, sw_reset_req, wdog_kick;
  logic       pll_resetb, sys_reset, cpu_reset;
  logic [1:0] rst_cause;
  logic [3:0] lock_fails;
  logic [2:0] seq_state;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .CNT_W       (16),
    .PLL_RST_CYC (PLL_RST_CYC),
    .LOCK_CYC    (LOCK_CYC),
    .LOCK_TO_CYC (LOCK_TO_CYC),
    .SYS_RST_CYC (SYS_RST_CYC),
    .CPU_DLY_CYC (CPU_DLY_CYC),
    .WDOG_CYC    (WDOG_CYC)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_pll_lock     (pll_lock),
    .i_sw_reset_req (sw_reset_req),
    .i_wdog_kick    (wdog_kick),
    .o_pll_resetb   (pll_resetb),
    .o_sys_reset    (sys_reset),
    .o_cpu_reset    (cpu_reset),
    .o_rst_cause    (rst_cause),
    .o_lock_fails   (lock_fails),
    .o_seq_state    (seq_state)
  );

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       pll;
    logic       sys;
    logic       cpu;
    logic [1:0] cause;
    logic [3:0] fails;
  } exp_t;

  typedef struct {
    int         ncyc;
    logic [2:0] st;
    logic       pll;
    logic       sys;
    logic       cpu;
  } vec_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_cause = 2'b00;
  logic [3:0] exp_fails = 4'd0;

  // Expected outputs of a state as the specification defines them
  function automatic exp_t mk(input string name, input logic [2:0] st);
    exp_t e;
    e.name  = name;
    e.st    = st;
    e.pll   = (st != 3'd0);
    e.sys   = (st <= 3'd2);
    e.cpu   = (st != 3'd4);
    e.cause = exp_cause;
    e.fails = exp_fails;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    e = sb_q.pop_front();
    n_checks++;
    if (seq_state !== e.st || pll_resetb !== e.pll || sys_reset !== e.sys ||
        cpu_reset !== e.cpu || rst_cause !== e.cause || lock_fails !== e.fails) begin
      n_fail++;
      $display("FAIL %s: got st=%0d pll=%b sys=%b cpu=%b cause=%b fails=%0d, required st=%0d pll=%b sys=%b cpu=%b cause=%b fails=%0d",
               e.name, seq_state, pll_resetb, sys_reset, cpu_reset, rst_cause, lock_fails,
               e.st, e.pll, e.sys, e.cpu, e.cause, e.fails);
    end
  endtask

  // Push expectation, advance n clock edges, compare 1 time unit after the edge
  task automatic run_check(input int n, input exp_t e);
    sb_q.push_back(e);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
    compare_head();
  endtask

  task automatic expect_after(input int n, input string name, input logic [2:0] st);
    run_check(n, mk(name, st));
  endtask

  task automatic wait_state(input logic [2:0] st, input int max, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(posedge clk);
      #1;
      if (seq_state == st) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: seq_state=%0d, required %0d within %0d cycles", name, seq_state, st, max);
    end
  endtask

  // Leaves reset released 1 time unit after a rising edge; next edge is E1
  task automatic do_reset(input logic lock);
    reset_n      = 1'b0;
    pll_lock     = lock;
    sw_reset_req = 1'b0;
    wdog_kick    = 1'b0;
    exp_cause    = 2'b00;
    exp_fails    = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    expect_after(0, "reset_hold", 3'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    exp_t e;
    bit   saw_sys;

    // Power-up with lock present: cumulative edges 0,3,4,12,13,22,23,25,26
    vecs[0] = '{0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{3, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1, 3'd1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8, 3'd1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1, 3'd2, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{9, 3'd2, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1, 3'd3, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{2, 3'd3, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1, 3'd4, 1'b1, 1'b0, 1'b0};

    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      e.name  = $sformatf("t1_vec%0d", i);
      e.st    = vecs[i].st;
      e.pll   = vecs[i].pll;
      e.sys   = vecs[i].sys;
      e.cpu   = vecs[i].cpu;
      e.cause = 2'b00;
      e.fails = 4'd0;
      run_check(vecs[i].ncyc, e);
    end

    // Software reset from RUN; a second request inside SYSRST is ignored
    sw_reset_req = 1'b1;
    exp_cause    = 2'b10;
    expect_after(1, "t4_sw_sysrst", 3'd2);
    expect_after(1, "t4_sw_ignored", 3'd2);
    sw_reset_req = 1'b0;
    expect_after(8, "t4_sysrst_hold", 3'd2);
    expect_after(1, "t4_cpurst", 3'd3);
    expect_after(2, "t4_cpurst_hold", 3'd3);
    expect_after(1, "t4_run_regained", 3'd4);

    // Lock drop takes two sync edges; sw request colliding with synced loss loses
    pll_lock = 1'b0;
    expect_after(1, "t5_sync1", 3'd4);
    expect_after(1, "t5_sync2", 3'd4);
    sw_reset_req = 1'b1;
    exp_cause    = 2'b01;
    expect_after(1, "t5_lockloss_prio", 3'd0);
    sw_reset_req = 1'b0;
    pll_lock     = 1'b1;
    wait_state(3'd4, 100, "t5_recover");
    expect_after(0, "t5_recovered", 3'd4);

    // Asynchronous reset in the middle of SYSRST
    sw_reset_req = 1'b1;
    exp_cause    = 2'b10;
    expect_after(1, "t5_sw_again", 3'd2);
    sw_reset_req = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n   = 1'b0;
    #1;
    exp_cause = 2'b00;
    expect_after(0, "t5_async_reset", 3'd0);

    // No lock: WAITLOCK timeouts every 68 edges, count saturates at 15
    do_reset(1'b0);
    for (int i = 1; i <= 20; i++) begin
      expect_after(67, $sformatf("t2_wait%0d", i), 3'd1);
      exp_fails = (i > 15) ? 4'd15 : 4'(i);
      expect_after(1, $sformatf("t2_timeout%0d", i), 3'd0);
    end

    // Lock chatter 7 high / 1 low never satisfies the filter
    do_reset(1'b1);
    saw_sys = 1'b0;
    for (int k = 0; k < 67; k++) begin
      pll_lock = ((k % 8) != 7);
      @(posedge clk);
      #1;
      if (seq_state == 3'd2) saw_sys = 1'b1;
    end
    expect_after(0, "t3_still_wait", 3'd1);
    pll_lock  = 1'b1;
    exp_fails = 4'd1;
    expect_after(1, "t3_timeout", 3'd0);
    n_checks++;
    if (saw_sys) begin
      n_fail++;
      $display("FAIL t3_chatter: reached SYSRST=1, required 0");
    end

    // Watchdog
    do_reset(1'b1);
    wait_state(3'd4, 100, "t6_reach_run");
`ifdef PLL_RST_WDOG_EN
    expect_after(31, "t6_wdog_pre", 3'd4);
    exp_cause = 2'b11;
    expect_after(1, "t6_wdog_fire", 3'd2);
    wait_state(3'd4, 50, "t6_rerun");
    repeat (31) @(posedge clk);
    #1;
    wdog_kick = 1'b1;
    expect_after(1, "t6_kick_tie", 3'd4);
    wdog_kick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (19) @(posedge clk);
      #1;
      wdog_kick = 1'b1;
      @(posedge clk);
      #1;
      wdog_kick = 1'b0;
    end
    expect_after(0, "t6_kicked_run", 3'd4);
`else
    expect_after(40, "t6_no_wdog", 3'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
